// File: rtl/uart_receiver_if.sv
// uart_receiver_if: receive-side signal bundle between the UART pin logic /
// register file and uart_receiver.
//   rec_en    receiver enable
//   comp      16-bit baud compare value (bit period = comp+1 clk cycles)
//   uart_rx   asynchronous serial line, idles high
//   rx_data   last received byte
//   rx_valid  one-cycle pulse, frame completed with good stop bit
//   frame_err one-cycle pulse, stop bit sampled low
//   busy_rx   receiver FSM not idle
// master: drives the controls/line (register file / bench); slave: the receiver.
interface uart_receiver_if #(
  parameter int unsigned DATA_W = 8
);
  logic              rec_en;
  logic [15:0]       comp;
  logic              uart_rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              busy_rx;

  modport master (
    output rec_en, comp, uart_rx,
    input  rx_data, rx_valid, frame_err, busy_rx
  );

  modport slave (
    input  rec_en, comp, uart_rx,
    output rx_data, rx_valid, frame_err, busy_rx
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1, LSB-first serial-to-parallel receive stage.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  uart_receiver_if.slave (rec_en, comp, uart_rx in;
//        rx_data, rx_valid, frame_err, busy_rx out)
// Parameters: DATA_W (8), SYNC_STAGES (>= 2) uart_rx synchronizer depth.
// Optional macro UART_RX_MAJORITY_EN: each sample point becomes a 2-of-3
// majority of rx_s around the bit centre; all outputs move one cycle later.
module uart_receiver #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  uart_receiver_if.slave bus
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                rx_s;
  logic                rx_prev_q;
  logic [15:0]         ce_q;
  logic [15:0]         cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                frame_err_q;

  logic [15:0]         comp_ce;
  logic [15:0]         half;
  logic [15:0]         start_pt;
  logic                samp;

  // Synchronizer; idles high so reset does not look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.uart_rx};
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign comp_ce  = (bus.comp < 16'd3) ? 16'd3 : bus.comp;
  assign half     = ce_q >> 1;

`ifdef UART_RX_MAJORITY_EN
  // Decision taken one cycle after the centre: rx_s (centre+1),
  // rx_prev_q (centre), maj2_q (centre-1).
  logic maj2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) maj2_q <= 1'b1;
    else     maj2_q <= rx_prev_q;
  end

  assign samp     = (rx_s & rx_prev_q) | (rx_s & maj2_q) | (rx_prev_q & maj2_q);
  assign start_pt = half + 16'd1;
`else
  assign samp     = rx_s;
  assign start_pt = half;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_prev_q   <= 1'b1;
      ce_q        <= 16'd3;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_prev_q   <= rx_s;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (!bus.rec_en) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_prev_q && !rx_s) begin
              state_q <= START;
              ce_q    <= comp_ce;
              // The edge cycle itself is count 0, so START begins at 1;
              // this lands every sample at t0 + half + k*(ce+1).
              cnt_q   <= 16'd1;
            end
          end
          START: begin
            if (cnt_q == start_pt) begin
              if (samp) begin
                state_q <= IDLE;
              end else begin
                state_q <= DATA;
                cnt_q   <= '0;
                idx_q   <= '0;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          DATA: begin
            if (cnt_q == ce_q) begin
              shift_q[idx_q] <= samp;
              cnt_q          <= '0;
              if (idx_q == LAST_IDX) state_q <= STOP;
              else                   idx_q   <= idx_q + 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          STOP: begin
            if (cnt_q == ce_q) begin
              // Leave at mid-stop so a back-to-back start edge is not missed.
              rx_data_q   <= shift_q;
              rx_valid_q  <= samp;
              frame_err_q <= !samp;
              cnt_q       <= '0;
              state_q     <= IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy_rx   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_receiver_if #(.DATA_W(8)) bus ();

  uart_receiver #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         gap;     // expected cycles since previous pulse, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_pulse = 0;
  logic prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic is_err, input logic [7:0] d, input int gap);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.gap    = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: every output pulse is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic pulse;
    pulse = (rst === 1'b0) && (bus.rx_valid === 1'b1 || bus.frame_err === 1'b1);
    if (pulse) begin
      check("no_dual_pulse", 32'(bus.rx_valid & bus.frame_err), 32'd0);
      check("pulse_one_cycle", 32'(prev_pulse), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=0x%0h expected no pulse",
                 bus.rx_valid, bus.frame_err, bus.rx_data);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_err", 32'(bus.frame_err), 32'(e.is_err));
        check("rx_data", 32'(bus.rx_data), 32'(e.data));
        if (e.gap > 0) begin
          checks++;
          if ((cyc - last_pulse) < e.gap - 1 || (cyc - last_pulse) > e.gap + 1) begin
            failures++;
            $display("FAIL pulse_gap: got %0d cycles expected %0d+-1", cyc - last_pulse, e.gap);
          end
        end
      end
      last_pulse = cyc;
    end
    prev_pulse = pulse;
  end

  task automatic wait_drain(input string name, input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d pulses pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // abort_kind 0: drop rec_en, 1: assert rst, at mid-bit of bit abort_at
  // (0 = start bit, 1..8 = data bits, 9 = stop bit).
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bitc,
                            input int abort_at, input int abort_kind);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      bus.uart_rx = bits[b];
      for (int c = 1; c < bitc; c++) begin
        @(negedge clk);
        if (b == abort_at && c == bitc / 2) begin
          if (abort_kind == 0) begin
            bus.rec_en = 1'b0;
          end else begin
            rst = 1'b1;
            #1;
            check("rst_rx_data", 32'(bus.rx_data), 32'd0);
            check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
            check("rst_frame_err", 32'(bus.frame_err), 32'd0);
            check("rst_busy", 32'(bus.busy_rx), 32'd0);
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int busy_cnt;
    rst         = 1'b1;
    bus.rec_en  = 1'b0;
    bus.comp    = 16'd15;
    bus.uart_rx = 1'b1;
    idle(3);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
    check("reset_busy", 32'(bus.busy_rx), 32'd0);
    rst = 1'b0;
    bus.rec_en = 1'b1;
    idle(5);

    // Normal byte at 16 clk/bit
    push(1'b0, 8'hA5, 0);
    send_frame(8'hA5, 1'b1, 16, -1, 0);
    wait_drain("normal", 60);
    idle(20);
    check("normal_busy_idle", 32'(bus.busy_rx), 32'd0);

    // False start: 4-cycle low glitch
    @(negedge clk);
    bus.uart_rx = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) bus.uart_rx = 1'b1;
      @(negedge clk);
      if (bus.busy_rx === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt < 5 || busy_cnt > 12) begin
      failures++;
      $display("FAIL false_start_busy: got %0d cycles expected 5..12", busy_cnt);
    end
    check("false_start_busy_idle", 32'(bus.busy_rx), 32'd0);
    check("false_start_data_held", 32'(bus.rx_data), 32'hA5);
    idle(10);

    // Framing error
    push(1'b1, 8'h3C, 0);
    send_frame(8'h3C, 1'b0, 16, -1, 0);
    @(negedge clk);
    bus.uart_rx = 1'b1;
    wait_drain("frame_err", 60);
    idle(20);

    // Back-to-back at 8 clk/bit, 80 cycles per frame
    bus.comp = 16'd7;
    push(1'b0, 8'h00, 0);
    push(1'b0, 8'hFF, 80);
    send_frame(8'h00, 1'b1, 8, -1, 0);
    send_frame(8'hFF, 1'b1, 8, -1, 0);
    wait_drain("back_to_back", 40);
    idle(20);

    // rec_en drop during data bit 3
    bus.comp = 16'd15;
    send_frame(8'h55, 1'b1, 16, 4, 0);
    idle(5);
    check("abort_busy_idle", 32'(bus.busy_rx), 32'd0);
    check("abort_data_held", 32'(bus.rx_data), 32'hFF);
    bus.rec_en = 1'b1;
    idle(10);
    push(1'b0, 8'h81, 0);
    send_frame(8'h81, 1'b1, 16, -1, 0);
    wait_drain("reenable", 60);
    idle(10);

    // Reset mid-frame
    send_frame(8'h5A, 1'b1, 16, 5, 1);
    idle(3);
    rst = 1'b0;
    idle(10);
    check("post_rst_busy", 32'(bus.busy_rx), 32'd0);
    check("post_rst_data", 32'(bus.rx_data), 32'd0);

    // Small divider clamped to 4 clk/bit
    bus.comp = 16'd1;
    push(1'b0, 8'h96, 0);
    send_frame(8'h96, 1'b1, 4, -1, 0);
    wait_drain("small_div", 30);
    idle(20);
    check("final_busy_idle", 32'(bus.busy_rx), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; the receive counterpart of uart_transmitter.
- Sits between the external uart_rx pin and the UART top register file, where it drives rx_data and the receive status.
- Frame format: 8N1, LSB first.
- Baud rate is set by the same 16-bit compare value (udvr) that the transmitter uses.

Parameters:
- DATA_W, 8, number of data bits per frame; only 8 is supported by the top.
- SYNC_STAGES, 2, flip-flop stages in the uart_rx synchronizer; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- rec_en  input  1  receiver enable
- comp  input  16  baud compare value; bit period = comp+1 clk cycles
- uart_rx  input  1  asynchronous serial input line, idles high
- rx_data  output  8  last received byte, held until the next completed frame
- rx_valid  output  1  one-cycle pulse: a frame completed with a good stop bit
- frame_err  output  1  one-cycle pulse: the stop bit was sampled low
- busy_rx  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface (decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_err = 0, busy_rx = 0.
  - FSM = IDLE.
  - All synchronizer flops = 1.
  - Bit counter = 0, baud counter = 0.
- Synchronizer: uart_rx passes through SYNC_STAGES flops to give rx_s; all decisions use rx_s only.
- Effective compare value: ce = max(comp, 3).
  - half = ce >> 1.
  - comp is sampled at start detection and held for the whole frame.
- Baud counter runs 0..ce, then wraps to 0.
- FSM states:
  - IDLE:
    - If rec_en = 1 and rx_s falls 1->0: go to START, clear the baud counter.
  - START:
    - At count == half, sample rx_s.
    - If rx_s = 1: false start; go to IDLE with no outputs.
    - If rx_s = 0: clear the counter and go to DATA with bit index 0.
  - DATA:
    - At each count == ce (mid-bit), shift rx_s into bit[index]. Bits arrive LSB first.
    - After index 7 is sampled, go to STOP.
  - STOP:
    - At count == ce, sample the stop bit.
    - Next cycle: rx_data <= shift register, in both the good-stop and bad-stop cases.
    - Stop bit = 1: pulse rx_valid. Stop bit = 0: pulse frame_err.
    - Go to IDLE immediately, at mid-stop, so that a back-to-back start edge can still be caught.
- Latency, with t0 = the cycle the rx_s falling edge is seen:
  - Data bit i is sampled at t0 + half + (i+1)*(ce+1).
  - The stop bit is sampled at t0 + half + 9*(ce+1).
  - rx_valid / frame_err is asserted one cycle after the stop sample.
- rec_en handling:
  - Deassertion in any state returns the FSM to IDLE on the next cycle.
  - No pulse is generated; rx_data is unchanged.
  - Assertion while rx_s = 0 does not start a frame; a falling edge is required.
- rx_valid and frame_err are never asserted together and never for more than one cycle.
- No backpressure: the consumer must capture rx_data before the next frame completes. A new frame overwrites rx_data.
- Reset mid-frame: everything returns to reset values immediately, with no pulse.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every sample point (start check, data bits, stop bit) takes rx_s at count-1, count and count+1.
  - The sampled value is the 2-of-3 majority.
  - The decision point moves to count+1; all outputs are delayed by 1 cycle relative to the base timing.
  - Sample points are unchanged relative to the bit centre.
- Undefined: single sample at the point given above; no extra flops.

Test Plan:
- Normal byte: comp=15, rec_en=1, drive 0xA5 8N1 at 16 clk/bit.
  - rx_data=0xA5 and a single rx_valid pulse.
  - frame_err stays 0; busy_rx returns to 0.
- False start: comp=15, pulse uart_rx low for 4 cycles, then high.
  - No rx_valid, no frame_err; rx_data unchanged.
  - busy_rx high for about 10 cycles, then back to IDLE.
- Framing error: comp=15, send 0x3C with stop bit = 0.
  - frame_err pulses once, rx_valid stays 0, rx_data=0x3C.
- Back-to-back frames: comp=7, send 0x00 then 0xFF with no idle gap.
  - Two rx_valid pulses 80±1 cycles apart.
  - rx_data reads 0x00, then 0xFF.
- Enable and reset abort:
  - Deassert rec_en during data bit 3 of 0x55: no pulse, rx_data holds its previous value.
  - Re-enable and send 0x81: rx_data=0x81.
  - Assert rst mid-frame: all outputs go to 0 immediately.
- Small divider: comp=1, clamped to ce=3, send 0x96 at 4 clk/bit.
  - rx_data=0x96 and rx_valid pulses.
